// File: rtl/edge_event_arbiter_if.sv
// Event port bundle between the edge-event arbiter (master) and its single consumer (slave).
interface edge_event_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic            evt_valid_o;
  logic            evt_ready_i;
  logic [CH_W-1:0] evt_ch_o;
  logic            evt_rising_o;

  modport master (
    output evt_valid_o,
    output evt_ch_o,
    output evt_rising_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_ch_o,
    input  evt_rising_o,
    output evt_ready_i
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel rising/falling edge detection with one pending slot per channel and a
// round-robin arbiter presenting events on a single valid/ready port.
module edge_event_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    a_i,
  input  logic [NUM_CH-1:0]    rise_en_i,
  input  logic [NUM_CH-1:0]    fall_en_i,
  edge_event_arbiter_if.master evt,
  output logic [NUM_CH-1:0]    overflow_o,
  input  logic                 ovf_clr_i
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] a_q_r;
  logic              primed_r;
  logic [NUM_CH-1:0] pend_vld_r;
  logic [NUM_CH-1:0] pend_pol_r;
  logic [NUM_CH-1:0] ovf_r;
  logic [CH_W-1:0]   ptr_r;
  logic              evt_valid_r;
  logic [CH_W-1:0]   evt_ch_r;
  logic              evt_rising_r;

  logic [NUM_CH-1:0] rise_s;
  logic [NUM_CH-1:0] fall_s;
  logic [NUM_CH-1:0] edge_s;
  logic              load_s;
  logic              arb_found_s;
  logic [CH_W:0]     arb_idx_s;
  logic [CH_W-1:0]   gnt_ch_s;
  logic [NUM_CH-1:0] gnt_oh_s;
  logic [NUM_CH-1:0] pend_vld_nxt_s;
  logic [NUM_CH-1:0] pend_pol_nxt_s;
  logic [NUM_CH-1:0] ovf_set_s;
  logic [NUM_CH-1:0] ovf_nxt_s;
  logic [CH_W-1:0]   ptr_nxt_s;
  logic              evt_valid_nxt_s;
  logic [CH_W-1:0]   evt_ch_nxt_s;
  logic              evt_rising_nxt_s;

  // Edge detection, suppressed until the first sample after reset has been captured.
  always_comb begin
    rise_s = {NUM_CH{1'b0}};
    fall_s = {NUM_CH{1'b0}};
    if (primed_r) begin
      rise_s = a_i & ~a_q_r & rise_en_i;
      fall_s = ~a_i & a_q_r & fall_en_i;
    end else begin
      rise_s = {NUM_CH{1'b0}};
      fall_s = {NUM_CH{1'b0}};
    end
    edge_s = rise_s | fall_s;
  end

  assign load_s = (~evt_valid_r | evt.evt_ready_i) & (|pend_vld_r);

  // Round-robin search starting at ptr_r, wrapping NUM_CH-1 back to 0.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = {(CH_W+1){1'b0}};
    gnt_ch_s    = {CH_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      arb_idx_s = {1'b0, ptr_r} + (CH_W+1)'(i);
      if (arb_idx_s >= (CH_W+1)'(NUM_CH)) begin
        arb_idx_s = arb_idx_s - (CH_W+1)'(NUM_CH);
      end else begin
        arb_idx_s = arb_idx_s;
      end
      if (!arb_found_s && pend_vld_r[arb_idx_s[CH_W-1:0]]) begin
        arb_found_s = 1'b1;
        gnt_ch_s    = arb_idx_s[CH_W-1:0];
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Grant one-hot and pointer advance; pointer only moves on an actual grant.
  always_comb begin
    gnt_oh_s  = {NUM_CH{1'b0}};
    ptr_nxt_s = ptr_r;
    if (load_s) begin
      gnt_oh_s[gnt_ch_s] = 1'b1;
      if (gnt_ch_s == CH_W'(NUM_CH-1)) begin
        ptr_nxt_s = {CH_W{1'b0}};
      end else begin
        ptr_nxt_s = gnt_ch_s + CH_W'(1);
      end
    end else begin
      gnt_oh_s  = {NUM_CH{1'b0}};
      ptr_nxt_s = ptr_r;
    end
  end

  // Pending slots: an edge into an occupied, ungranted slot is dropped and flagged.
  always_comb begin
    pend_vld_nxt_s = pend_vld_r;
    pend_pol_nxt_s = pend_pol_r;
    ovf_set_s      = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (edge_s[c]) begin
        if (pend_vld_r[c] && !gnt_oh_s[c]) begin
          ovf_set_s[c] = 1'b1;
        end else begin
          pend_vld_nxt_s[c] = 1'b1;
          pend_pol_nxt_s[c] = rise_s[c];
        end
      end else if (gnt_oh_s[c]) begin
        pend_vld_nxt_s[c] = 1'b0;
      end else begin
        pend_vld_nxt_s[c] = pend_vld_r[c];
      end
    end
  end

  // Sticky overflow: a new set beats a simultaneous clear.
  always_comb begin
    ovf_nxt_s = ovf_r;
    if (ovf_clr_i) begin
      ovf_nxt_s = ovf_set_s;
    end else begin
      ovf_nxt_s = ovf_r | ovf_set_s;
    end
  end

  // Output register: reload on a free or accepting port, hold while stalled.
  always_comb begin
    evt_valid_nxt_s  = evt_valid_r;
    evt_ch_nxt_s     = evt_ch_r;
    evt_rising_nxt_s = evt_rising_r;
    if (load_s) begin
      evt_valid_nxt_s  = 1'b1;
      evt_ch_nxt_s     = gnt_ch_s;
      evt_rising_nxt_s = pend_pol_r[gnt_ch_s];
    end else if (evt.evt_ready_i) begin
      evt_valid_nxt_s  = 1'b0;
    end else begin
      evt_valid_nxt_s  = evt_valid_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q_r        <= {NUM_CH{1'b0}};
      primed_r     <= 1'b0;
      pend_vld_r   <= {NUM_CH{1'b0}};
      pend_pol_r   <= {NUM_CH{1'b0}};
      ovf_r        <= {NUM_CH{1'b0}};
      ptr_r        <= {CH_W{1'b0}};
      evt_valid_r  <= 1'b0;
      evt_ch_r     <= {CH_W{1'b0}};
      evt_rising_r <= 1'b0;
    end else begin
      a_q_r        <= a_i;
      primed_r     <= 1'b1;
      pend_vld_r   <= pend_vld_nxt_s;
      pend_pol_r   <= pend_pol_nxt_s;
      ovf_r        <= ovf_nxt_s;
      ptr_r        <= ptr_nxt_s;
      evt_valid_r  <= evt_valid_nxt_s;
      evt_ch_r     <= evt_ch_nxt_s;
      evt_rising_r <= evt_rising_nxt_s;
    end
  end

  assign evt.evt_valid_o  = evt_valid_r;
  assign evt.evt_ch_o     = evt_ch_r;
  assign evt.evt_rising_o = evt_rising_r;
  assign overflow_o       = ovf_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed, table-driven bench for edge_event_arbiter with NUM_CH = 4.
module tb_edge_event_arbiter;
  localparam int NUM_CH = 4;

  typedef struct {
    logic [3:0] a;
    logic [3:0] ren;
    logic [3:0] fen;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [1:0] ech;
    logic       er;
    logic [3:0] eovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a_i;
  logic [3:0] rise_en_i;
  logic [3:0] fall_en_i;
  logic [3:0] overflow_o;
  logic       ovf_clr_i;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  edge_event_arbiter_if #(.NUM_CH(NUM_CH)) evt_bus ();

  edge_event_arbiter #(.NUM_CH(NUM_CH)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_i        (a_i),
    .rise_en_i  (rise_en_i),
    .fall_en_i  (fall_en_i),
    .evt        (evt_bus),
    .overflow_o (overflow_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, row, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] a, input logic [3:0] ren, input logic [3:0] fen,
                     input logic rdy, input logic clr, input logic ev, input logic [1:0] ech,
                     input logic er, input logic [3:0] eovf);
    vec_t v;
    v.a = a; v.ren = ren; v.fen = fen; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ech = ech; v.er = er; v.eovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Line high through reset: priming must swallow it.
    for (int i = 0; i < 5; i++) add(4'h1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    // Single rise on ch2, valid for exactly one cycle.
    add(4'h5, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h5, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'h0);
    add(4'h5, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    // ch3 event moves the pointer back to 0.
    add(4'h8, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h8, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'h0);
    add(4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    // Burst on ch0, ch1, ch3.
    add(4'hB, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'hB, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'h0);
    add(4'hB, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0);
    add(4'hB, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'h0);
    add(4'hB, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    // Burst on ch0, ch1 with pointer at 0.
    add(4'h3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'h0);
    add(4'h3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0);
    add(4'h3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    // Stalled port: ch1 rise held, fall fills slot, second rise overflows, clear.
    add(4'h2, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h2, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0);
    add(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0);
    add(4'h2, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'h2);
    add(4'h2, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'h2);
    add(4'h2, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 4'h0);
    add(4'h2, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'h0);
    add(4'h2, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    // Overflow set and clear in the same cycle: set wins; older event survives.
    add(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'h0);
    add(4'h2, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'h0);
    add(4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'h2);
    add(4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'h0);
    add(4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0);
    add(4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    // Edge on the cycle its slot is granted: reloads, no overflow.
    add(4'h2, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h2, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0);
    add(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0);
    add(4'h2, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'h0);
    add(4'h2, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0);
    add(4'h2, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    // Falling edges disabled: ch3 pulse yields only the rising event.
    add(4'hA, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h2, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'h0);
    add(4'h2, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h2, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    // Pending event still delivered after its enable drops.
    add(4'h3, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    add(4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'h0);
    add(4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);

    reset = 1'b0;
    a_i = 4'h1; rise_en_i = 4'hF; fall_en_i = 4'hF; ovf_clr_i = 1'b0;
    evt_bus.evt_ready_i = 1'b1;
    step();
    step();
    chk("rst_valid", -1, int'(evt_bus.evt_valid_o), 0);
    chk("rst_ch", -1, int'(evt_bus.evt_ch_o), 0);
    chk("rst_rising", -1, int'(evt_bus.evt_rising_o), 0);
    chk("rst_ovf", -1, int'(overflow_o), 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      a_i = vecs[i].a; rise_en_i = vecs[i].ren; fall_en_i = vecs[i].fen;
      evt_bus.evt_ready_i = vecs[i].rdy; ovf_clr_i = vecs[i].clr;
      step();
      chk("valid", i, int'(evt_bus.evt_valid_o), int'(vecs[i].ev));
      chk("ovf", i, int'(overflow_o), int'(vecs[i].eovf));
      if (vecs[i].ev) begin
        chk("ch", i, int'(evt_bus.evt_ch_o), int'(vecs[i].ech));
        chk("rising", i, int'(evt_bus.evt_rising_o), int'(vecs[i].er));
      end
    end

    // Reset mid-transfer with two slots still pending (pointer at 1 here).
    a_i = 4'h0; fall_en_i = 4'h0; rise_en_i = 4'hF; ovf_clr_i = 1'b0;
    evt_bus.evt_ready_i = 1'b1;
    step();
    chk("mid_idle", 100, int'(evt_bus.evt_valid_o), 0);
    a_i = 4'h7; fall_en_i = 4'hF; evt_bus.evt_ready_i = 1'b0;
    step();
    step();
    chk("mid_valid", 101, int'(evt_bus.evt_valid_o), 1);
    chk("mid_ch", 101, int'(evt_bus.evt_ch_o), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_valid", 102, int'(evt_bus.evt_valid_o), 0);
    chk("async_ch", 102, int'(evt_bus.evt_ch_o), 0);
    step();
    reset = 1'b1;
    evt_bus.evt_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stale_valid", 103 + k, int'(evt_bus.evt_valid_o), 0);
      chk("stale_ovf", 103 + k, int'(overflow_o), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event controller for the edge-detector datapath.
- Each of NUM_CH input lines gets a per-channel rising/falling edge detector, masked by per-channel enables.
- Detected edges are held as pending events. A round-robin arbiter shares one valid/ready event port between the channels and reports channel ID and edge polarity.
- Sits between raw synchronised status lines and a single consumer, such as an interrupt or logging unit.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- CH_W, $clog2(NUM_CH), width of the channel ID. Derived; not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset: low clears all state immediately.
- a_i  input  NUM_CH  level inputs, already synchronous to clk.
- rise_en_i  input  NUM_CH  per-channel rising-edge detect enable.
- fall_en_i  input  NUM_CH  per-channel falling-edge detect enable.
- evt_valid_o  output  1  event available.
- evt_ready_i  input  1  consumer accepts event when high with evt_valid_o.
- evt_ch_o  output  CH_W  channel of the presented event.
- evt_rising_o  output  1  1 = rising edge, 0 = falling edge.
- overflow_o  output  NUM_CH  sticky per-channel lost-event flag.
- ovf_clr_i  input  1  clears all overflow_o bits.

Behaviour:
- Reset values: evt_valid_o=0, evt_ch_o=0, evt_rising_o=0, overflow_o=0. Also cleared: all pending slots, previous-sample register a_q, the primed flag, and the RR pointer (=0).
- Priming: the first posedge after reset release loads a_q from a_i, sets primed, and detects no edges. This means a line held high through reset never produces a spurious rising event.
- Detection, each posedge once primed:
  - rise[c] = a_i[c] & ~a_q[c] & rise_en_i[c].
  - fall[c] = ~a_i[c] & a_q[c] & fall_en_i[c].
  - a_q updates every cycle regardless of enables.
- Pending slot, one per channel, holding {valid, polarity}. A detected edge loads the slot at that posedge.
  - Edge while slot occupied and not granted that cycle: slot keeps the older event and overflow_o[c] sets.
  - Edge on the same cycle the slot is granted: the new edge loads the slot, no overflow.
- Enable deassertion masks only new edges; already-pending events are still delivered.
- Output register: loads at a posedge when (~evt_valid_o | evt_ready_i) and any slot is pending.
  - The winner's slot clears and its ID and polarity load into evt_ch_o and evt_rising_o.
  - evt_valid_o is set.
- If no slot is pending and evt_ready_i is high, evt_valid_o clears.
- While evt_valid_o & ~evt_ready_i, evt_ch_o and evt_rising_o are held stable.
- Latency: edge sampled at posedge k, pending at k, evt_valid_o high after posedge k+1 (idle port). Back-to-back events are deliverable one per cycle while evt_ready_i stays high.
- Arbitration: round-robin.
  - The search starts at channel ptr and wraps NUM_CH-1 → 0.
  - After a grant to channel g, ptr = (g+1) mod NUM_CH.
  - ptr is unchanged when nothing is granted.
- overflow_o:
  - Sets per the pending-slot rules above.
  - ovf_clr_i clears all bits at the posedge.
  - A set and a clear on the same channel in the same cycle: set wins.
- Reset asserted mid-transfer: evt_valid_o drops immediately and pending events are discarded.

Test Plan:
- Hold a_i=4'b0001 through reset and release → no event in the first 5 cycles; overflow_o=0.
- Ch2 rises at posedge k (rise_en=4'hF, evt_ready_i=1) → evt_valid_o=1 after posedge k+1 with evt_ch_o=2, evt_rising_o=1, valid for exactly 1 cycle.
- Ch0, ch1 and ch3 rise in the same cycle with ready=1 → events delivered in order ch 0, 1, 3 on consecutive cycles. Next simultaneous burst on ch0 and ch1 → order 0, 1; ptr started at 0 after the ch3 grant.
- evt_ready_i=0, ch1 rises then falls while its slot is full → first event (ch1, rising) is held stable and overflow_o=4'b0010. ovf_clr_i pulse → overflow_o=0.
- fall_en_i=0, rise_en_i=4'hF, toggle ch3 0→1→0 → only one event (ch3, rising); no falling event.
- Pull reset low while evt_valid_o=1 with 2 slots pending → evt_valid_o=0 asynchronously. After release plus priming, no stale events appear.
